// File: rtl/fsk_pkg.sv
// fsk_pkg: shared state codes and elaboration helpers for the M-ary FSK modulator.
package fsk_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    function automatic int sym_div(input int clk_hz, input int sym_rate_hz);
        return clk_hz / sym_rate_hz;
    endfunction

    function automatic int nsym(input int bits_per_sym);
        return 8 / bits_per_sym;
    endfunction

    function automatic int midscale(input int dac_w);
        return 2 ** (dac_w - 1);
    endfunction

endpackage

// File: rtl/fsk_sine_rom.sv
// fsk_sine_rom: registered full-wave offset-binary sine table, built at elaboration.
module fsk_sine_rom
    import fsk_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int DAC_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LUT_AW-1:0] addr,
    output logic [DAC_W-1:0]  data
);

    localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W));

    // Bhaskara rational sine on each half-wave keeps the table pure integer math.
    function automatic logic [DAC_W-1:0] sine_at(input longint a);
        longint h, n, p, den, amp, mag;
        h   = longint'(1 << (LUT_AW - 1));
        n   = a % h;
        p   = n * (h - n);
        den = 5 * h * h - 4 * p;
        amp = longint'((1 << (DAC_W - 1)) - 1);
        mag = (amp * 16 * p + den / 2) / den;
        return (a < h) ? MID + DAC_W'(mag) : MID - DAC_W'(mag);
    endfunction

    logic [DAC_W-1:0] rom [2**LUT_AW];
    logic [DAC_W-1:0] data_q, data_d;

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        localparam logic [DAC_W-1:0] V = sine_at(longint'(i));
        assign rom[i] = V;
    end

    always_comb data_d = rom[addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) data_q <= MID;
        else data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/fsk_mary_modulator.sv
// fsk_mary_modulator: M-ary continuous-phase FSK modulator with byte FIFO,
// programmable tuning-word table, phase accumulator and sine ROM output.
module fsk_mary_modulator
    import fsk_pkg::*;
#(
    parameter int                 CLK_HZ       = 50_000_000,
    parameter int                 SYM_RATE_HZ  = 1_000,
    parameter int                 SAMPLE_DIV   = 64,
    parameter int                 BITS_PER_SYM = 1,
    parameter int                 PHASE_W      = 24,
    parameter int                 LUT_AW       = 8,
    parameter int                 DAC_W        = 12,
    parameter int                 FIFO_DEPTH   = 4,
    parameter logic [PHASE_W-1:0] BASE_FTW     = PHASE_W'(33554),
    parameter logic [PHASE_W-1:0] STEP_FTW     = PHASE_W'(33554)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    tone_wr,
    input  logic [BITS_PER_SYM-1:0] tone_addr,
    input  logic [PHASE_W-1:0]      tone_word,
    output logic [DAC_W-1:0]        dac_data,
    output logic                    sample_stb,
    output logic                    sym_tick,
    output logic                    busy
);

    localparam int SD = sym_div(CLK_HZ, SYM_RATE_HZ);
    localparam int NS = nsym(BITS_PER_SYM);
    localparam int M  = 2 ** BITS_PER_SYM;
    localparam int TW = $clog2(SD);
    localparam int SW = $clog2(SAMPLE_DIV);
    localparam int FA = $clog2(FIFO_DEPTH);
    localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W));

    logic [TW-1:0]           sym_cnt_q, sym_cnt_d;
    logic [SW-1:0]           smp_cnt_q, smp_cnt_d;
    logic [7:0]              fifo_q [FIFO_DEPTH];
    logic [7:0]              fifo_d [FIFO_DEPTH];
    logic [FA:0]             wr_q, wr_d, rd_q, rd_d;
    logic [0:0]              state_q, state_d;
    logic [7:0]              shreg_q, shreg_d;
    logic [2:0]              scnt_q, scnt_d;
    logic [PHASE_W-1:0]      ftw_q [M];
    logic [PHASE_W-1:0]      ftw_d [M];
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [DAC_W-1:0]        dac_q, dac_d;
    logic [DAC_W-1:0]        rom_data;
    logic [BITS_PER_SYM-1:0] cur_sym;
    logic                    empty, full, push, pop, last;

    assign sym_tick   = sym_cnt_q == TW'(SD - 1);
    assign sample_stb = smp_cnt_q == SW'(SAMPLE_DIV - 1);
    assign empty      = wr_q == rd_q;
    assign full       = (wr_q[FA] != rd_q[FA]) && (wr_q[FA-1:0] == rd_q[FA-1:0]);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign busy       = !empty || (state_q == SHIFT);
    // Idle transmits mark: the all-ones symbol.
    assign cur_sym    = (state_q == SHIFT) ? shreg_q[BITS_PER_SYM-1:0] : '1;
    assign dac_data   = dac_q;

    always_comb begin
        sym_cnt_d = sym_tick ? '0 : sym_cnt_q + 1'b1;
        smp_cnt_d = sample_stb ? '0 : smp_cnt_q + 1'b1;
        last      = (state_q == IDLE) || (scnt_q == 3'(NS - 1));
        pop       = sym_tick && last && !empty;
        state_d   = !sym_tick ? state_q : ((pop || !last) ? SHIFT : IDLE);
        shreg_d   = pop ? fifo_q[rd_q[FA-1:0]] : ((sym_tick && !last) ? shreg_q >> BITS_PER_SYM : shreg_q);
        scnt_d    = pop ? '0 : ((sym_tick && !last) ? scnt_q + 1'b1 : scnt_q);
        wr_d      = wr_q + (FA + 1)'(push);
        rd_d      = rd_q + (FA + 1)'(pop);
        fifo_d    = fifo_q;
        if (push) fifo_d[wr_q[FA-1:0]] = in_data;
        ftw_d     = ftw_q;
        if (tone_wr) ftw_d[tone_addr] = tone_word;
        // Accumulator is never cleared on symbol changes, so the phase stays continuous.
        phase_d   = phase_q + ftw_q[cur_sym];
        dac_d     = rom_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_cnt_q <= '0;
            smp_cnt_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            state_q   <= IDLE;
            shreg_q   <= '0;
            scnt_q    <= '0;
            phase_q   <= '0;
            dac_q     <= MID;
            for (int k = 0; k < FIFO_DEPTH; k++) fifo_q[k] <= '0;
            for (int k = 0; k < M; k++) ftw_q[k] <= BASE_FTW + PHASE_W'(k) * STEP_FTW;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scnt_q    <= scnt_d;
            phase_q   <= phase_d;
            dac_q     <= dac_d;
            fifo_q    <= fifo_d;
            ftw_q     <= ftw_d;
        end
    end

    fsk_sine_rom #(
        .LUT_AW(LUT_AW),
        .DAC_W (DAC_W)
    ) u_rom (
        .clk  (clk),
        .reset(reset),
        .addr (phase_q[PHASE_W-1 -: LUT_AW]),
        .data (rom_data)
    );

endmodule

// File: tb/tb_fsk_mary_modulator.sv
// tb_fsk_mary_modulator: random byte/tone stimulus against a queue-based behavioural
// model; a negedge monitor scores every sample and symbol strobe.
`timescale 1ns/1ps
module tb_fsk_mary_modulator;

    localparam int CLK_HZ = 20_000, SYM_RATE_HZ = 1_000, SD = CLK_HZ / SYM_RATE_HZ;
    localparam int SMP = 4, B = 2, M = 4, NS = 4, DEPTH = 4;
    localparam int PW = 24, LA = 8, DW = 12, MID = 2048, AMP = 2047, TOL = 6;
    localparam logic [PW-1:0] BASE = 24'h020000, STEP = 24'h018000;

    logic          clk = 0, reset = 0;
    logic [7:0]    in_data = 0;
    logic          in_valid = 0, tone_wr = 0;
    logic [B-1:0]  tone_addr = 0;
    logic [PW-1:0] tone_word = 0;
    logic          in_ready, sample_stb, sym_tick, busy;
    logic [DW-1:0] dac_data;
    int            total = 0, passed = 0;

    always #5 clk = ~clk;

    fsk_mary_modulator #(
        .CLK_HZ(CLK_HZ), .SYM_RATE_HZ(SYM_RATE_HZ), .SAMPLE_DIV(SMP), .BITS_PER_SYM(B),
        .PHASE_W(PW), .LUT_AW(LA), .DAC_W(DW), .FIFO_DEPTH(DEPTH), .BASE_FTW(BASE), .STEP_FTW(STEP)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tone_wr(tone_wr), .tone_addr(tone_addr), .tone_word(tone_word), .dac_data(dac_data),
        .sample_stb(sample_stb), .sym_tick(sym_tick), .busy(busy)
    );

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic chk_tol(input string nm, input int got, input int exp);
        total++;
        if (got >= exp - TOL && got <= exp + TOL) passed++;
        else $display("FAIL %s: got %0d expected %0d +/- %0d", nm, got, exp, TOL);
    endtask

    // Ideal sine of the truncated ROM index.
    function automatic int s_of(input logic [PW-1:0] ph);
        real ang;
        ang = 2.0 * 3.14159265358979 * real'(ph[PW-1 -: LA]) / 256.0;
        return MID + int'(AMP * $sin(ang));
    endfunction

    logic [PW-1:0] m_ftw [M];
    logic [PW-1:0] m_ph;
    int            m_k, m_rom, m_dac, m_cur;
    int            m_pend[$];
    logic [7:0]    m_fq[$];
    int            sq_dac[$];
    bit            sq_rdy[$], sq_busy[$], tq_busy[$];

    task automatic m_reset();
        m_ph = 0; m_k = 0; m_rom = MID; m_dac = MID; m_cur = -1;
        m_pend.delete(); m_fq.delete();
        sq_dac.delete(); sq_rdy.delete(); sq_busy.delete(); tq_busy.delete();
        for (int k = 0; k < M; k++) m_ftw[k] = PW'(BASE + STEP * k);
    endtask

    task automatic m_step();
        bit         acc, tick, mbusy;
        logic [7:0] b;
        acc   = in_valid && m_fq.size() < DEPTH;
        tick  = (m_k % SD) == SD - 1;
        m_dac = m_rom;
        m_rom = s_of(m_ph);
        m_ph  = m_ph + m_ftw[m_cur < 0 ? M - 1 : m_cur];
        if (tone_wr) m_ftw[tone_addr] = tone_word;
        if (tick) begin
            if (m_pend.size() == 0 && m_fq.size() > 0) begin
                b = m_fq.pop_front();
                for (int i = 0; i < NS; i++) m_pend.push_back(int'(b >> (i * B)) % M);
            end
            m_cur = (m_pend.size() > 0) ? m_pend.pop_front() : -1;
        end
        if (acc) m_fq.push_back(in_data);
        m_k++;
        mbusy = m_fq.size() > 0 || m_cur >= 0;
        if (m_k % SMP == SMP - 1) begin
            sq_dac.push_back(m_dac);
            sq_rdy.push_back(m_fq.size() < DEPTH);
            sq_busy.push_back(mbusy);
        end
        if (m_k % SD == SD - 1) tq_busy.push_back(mbusy);
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) m_reset();
        else m_step();
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            bit es, et, r, bz;
            int d;
            es = sq_dac.size() > 0;
            chk("sample_stb", int'(sample_stb), int'(es));
            if (es) begin
                d = sq_dac.pop_front(); r = sq_rdy.pop_front(); bz = sq_busy.pop_front();
                if (sample_stb) begin
                    chk_tol("dac_data", int'(dac_data), d);
                    chk("in_ready", int'(in_ready), int'(r));
                    chk("busy", int'(busy), int'(bz));
                end
            end
            et = tq_busy.size() > 0;
            chk("sym_tick", int'(sym_tick), int'(et));
            if (et) begin
                bz = tq_busy.pop_front();
                if (sym_tick) chk("busy_at_tick", int'(busy), int'(bz));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b, output int waits);
        bit r, ok;
        ok = 0; waits = 0;
        in_data = b; in_valid = 1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #2;
            if (r) ok = 1;
            else waits++;
        end
        in_valid = 0;
        chk("send_accept", int'(ok), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            cycles(1);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic reset_pulse();
        reset = 0;
        #1;
        chk("rst_dac", int'(dac_data), MID);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_stb", int'(sample_stb), 0);
        chk("rst_tick", int'(sym_tick), 0);
        cycles(3);
        reset = 1;
    endtask

    task automatic write_tone(input logic [B-1:0] a, input logic [PW-1:0] w);
        tone_wr = 1; tone_addr = a; tone_word = w;
        cycles(1);
        tone_wr = 0;
    endtask

    initial begin
        int w, n;
        cycles(2);
        reset_pulse();
        cycles(60);
        send(8'h1B, w);
        wait_idle();
        cycles(10);
        // Start the burst right after a boundary so the FIFO fills before the first pop.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sym_tick && n < 100);
        chk("tick_seen", int'(sym_tick), 1);
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), w);
        send(8'h3C, w);
        chk("fifth_refused", int'(w > 0), 1);
        wait_idle();
        write_tone(2'd3, 24'h0D0000);
        cycles(60);
        for (int i = 0; i < 20; i++) begin
            cycles($urandom_range(0, 30));
            if ($urandom_range(0, 2) == 0)
                write_tone(B'($urandom_range(0, M - 1)), PW'($urandom_range(24'h010000, 24'h0C0000)));
            send(8'($urandom_range(0, 255)), w);
        end
        cycles(30);
        reset_pulse();
        cycles(50);
        send(8'h5A, w);
        wait_idle();
        cycles(20);
        @(negedge clk);
        #1;
        chk("sample_queue_drained", sq_dac.size(), 0);
        chk("tick_queue_drained", tq_busy.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
